imem_responder: RTL and testbench
=================================

Name: imem_responder

Overview:
- Responder side of the instruction-fetch interface: accepts PC requests from fetch and returns instruction words through a valid/ready handshake.
- Holds the instruction store and a 2-entry response queue, which absorbs backpressure from downstream decode.
- Provides a program-load write port for the boot/test loader.
- Accepts a flush on branch redirect, which discards responses for the stale path.

Parameters:
DEPTH_WORDS, 256, number of 32-bit instruction words in the store (power of two)
NOP_INSTR, 32'h00000013, instruction returned on faulting requests (addi x0,x0,0)

Ports:
clk  input  1  clock, rising-edge active
reset  input  1  synchronous, active-high reset
req_valid  input  1  fetch presents a request
req_ready  output  1  responder can accept a request this cycle
req_pc  input  32  byte address of the requested instruction
rsp_valid  output  1  head of the response queue is valid
rsp_ready  input  1  consumer takes the head response this cycle
rsp_instr  output  32  instruction word at the queue head
rsp_pc  output  32  PC that produced the head response
rsp_fault  output  1  head response came from a misaligned or out-of-range PC
flush  input  1  drop all queued responses (branch redirect)
load_en  input  1  write load_data into the store
load_addr  input  32  byte address of the load write
load_data  input  32  word to write

Behaviour:
- Clocking and reset: single clock domain, clk rising edge. Reset is synchronous and active-high; all state changes happen on the rising edge.
- Reset: queue emptied (count=0); rsp_valid=0, rsp_instr=0, rsp_pc=0, rsp_fault=0. req_ready=0 while reset is high and 1 in the first cycle after. Store contents are not cleared. A load_en during reset is ignored. A reset mid-operation discards queued responses immediately.
- Word index: idx = pc[log2(DEPTH_WORDS)+1:2].
- Fault rule: fault = (pc[1:0] != 0) OR (pc >= 4*DEPTH_WORDS). A faulting entry carries instr=NOP_INSTR, fault=1 and the original pc.
- req_ready = !reset && !flush && (count < 2).
  - Combinational from registered count and flush only; it does not depend on rsp_ready.
- Accept: when req_valid && req_ready at edge E, the store is read and the entry {instr, pc, fault} is pushed at E. rsp_valid is visible in the cycle after E (1-cycle latency).
- Pop: when rsp_valid && rsp_ready at an edge, the head is removed.
- Queue organisation: 2-entry circular buffer with 1-bit read/write pointers that wrap 1->0, plus a 2-bit count.
- Count update:
  - Push alone: +1.
  - Pop alone: -1.
  - Push and pop together (only possible at count=1): count unchanged, order preserved.
- Full (count=2): req_ready=0; the request is held by fetch (req_valid and req_pc stable until accepted).
- Empty (count=0): rsp_valid=0; rsp_instr, rsp_pc and rsp_fault are all driven 0.
- Ordering: responses leave strictly in acceptance order.
- Flush:
  - At the edge: count=0 and both pointers=0.
  - Any pop in the same cycle is discarded.
  - No request is accepted in a flush cycle, because req_ready=0.
- Load:
  - When load_en at an edge and load_addr is aligned and in range, store[idx(load_addr)] <= load_data.
  - A misaligned or out-of-range load is silently dropped.
- Load/read collision (same index, same edge): the request returns the old word (read-before-write). The next request to that index returns the new word.
- Loads are independent of the handshake and of flush.
- Store: synchronous-write array, DEPTH_WORDS x 32. The read data is captured into the queue entry at the accept edge, with no separate read register.

Test Plan:
- Load words 0x00500093 @0x0 and 0x00A00113 @0x4; issue requests pc=0x0 then 0x4 with rsp_ready=1 -> rsp_valid one cycle after each accept, with rsp_instr=0x00500093 / rsp_pc=0x0 and then rsp_instr=0x00A00113 / rsp_pc=0x4, rsp_fault=0.
- Hold rsp_ready=0 and issue 3 back-to-back requests at 0x0, 0x4, 0x8 -> req_ready drops after 2 accepts and the third request stalls. Raise rsp_ready -> responses drain in order 0x0, 0x4, 0x8, and the third request is accepted the cycle after count falls to 1.
- Request pc=0x2 and pc=0x400 (DEPTH_WORDS=256) -> both responses have rsp_fault=1 and rsp_instr=0x00000013, with rsp_pc equal to the original pc.
- Queue two responses, then assert flush with rsp_ready=1 and req_valid=1 -> after the edge rsp_valid=0 and count=0, req_ready=0 during the flush cycle, and no response for the flushed or concurrent request ever appears.
- Same-edge collision: load_en with 0xDEADBEEF @0x8 while a request for pc=0x8 is accepted -> the response carries the old word. A following request for 0x8 returns 0xDEADBEEF.
- Assert reset for 1 cycle while count=2 -> next cycle rsp_valid=0 and all rsp_* outputs 0, req_ready=1, and the loaded store contents still read back unchanged.

Source files
------------

// File: rtl/imem_responder.sv
// Instruction-fetch responder: an instruction store with a program-load port, and a
// 2-entry response queue that absorbs decode backpressure and is cleared by flush.
module imem_responder #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter logic [31:0] NOP_INSTR   = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_pc,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_instr,
  output logic [31:0] rsp_pc,
  output logic        rsp_fault,
  input  logic        flush,
  input  logic        load_en,
  input  logic [31:0] load_addr,
  input  logic [31:0] load_data
);

  localparam int unsigned AW    = $clog2(DEPTH_WORDS);
  localparam logic [32:0] LIMIT = 33'(DEPTH_WORDS) * 33'd4;

  logic [31:0] store [DEPTH_WORDS];

  logic [31:0] q_instr [2];
  logic [31:0] q_pc    [2];
  logic        q_fault [2];
  logic        rd_ptr;
  logic        wr_ptr;
  logic [1:0]  count;

  logic          push;
  logic          pop;
  logic          req_fault;
  logic          load_fault;
  logic [AW-1:0] req_idx;
  logic [AW-1:0] load_idx;

  function automatic logic addr_fault(input logic [31:0] a);
    return (a[1:0] != 2'b00) || ({1'b0, a} >= LIMIT);
  endfunction

  always_comb begin
    req_idx    = req_pc[AW+1:2];
    load_idx   = load_addr[AW+1:2];
    req_fault  = addr_fault(req_pc);
    load_fault = addr_fault(load_addr);
    req_ready  = !reset && !flush && (count < 2'd2);
    rsp_valid  = (count != 2'd0);
    push       = req_valid && req_ready;
    pop        = rsp_valid && rsp_ready;
    rsp_instr  = rsp_valid ? q_instr[rd_ptr] : '0;
    rsp_pc     = rsp_valid ? q_pc[rd_ptr]    : '0;
    rsp_fault  = rsp_valid ? q_fault[rd_ptr] : 1'b0;
  end

  // Store write; a same-edge request read sees the pre-write word.
  always_ff @(posedge clk) begin
    if (!reset && load_en && !load_fault) begin
      store[load_idx] <= load_data;
    end
  end

  // Queue payload needs no reset: it is only observed while count says it is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      q_instr[wr_ptr] <= req_fault ? NOP_INSTR : store[req_idx];
      q_pc[wr_ptr]    <= req_pc;
      q_fault[wr_ptr] <= req_fault;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      count  <= '0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_responder.sv
// Scoreboard bench for imem_responder: stimulus queues expected responses, and a
// monitor pops and compares them whenever a response is handed over.
module tb_imem_responder;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] W0  = 32'h0050_0093;
  localparam logic [31:0] W1  = 32'h00A0_0113;
  localparam logic [31:0] W2  = 32'h00F0_0193;
  localparam logic [31:0] WD  = 32'hDEAD_BEEF;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_pc = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_instr;
  logic [31:0] rsp_pc;
  logic        rsp_fault;
  logic        flush = 1'b0;
  logic        load_en = 1'b0;
  logic [31:0] load_addr = '0;
  logic [31:0] load_data = '0;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        fault;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  imem_responder #(.DEPTH_WORDS(256), .NOP_INSTR(NOP)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_pc(req_pc),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_instr(rsp_instr),
    .rsp_pc(rsp_pc), .rsp_fault(rsp_fault),
    .flush(flush), .load_en(load_en), .load_addr(load_addr), .load_data(load_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // A response is consumed at the next edge whenever valid&&ready and no flush/reset.
  always @(negedge clk) begin
    if (!reset && !flush && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_rsp: got pc %h instr %h expected none", rsp_pc, rsp_instr);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("rsp_instr", rsp_instr, e.instr);
        chk("rsp_pc", rsp_pc, e.pc);
        chk("rsp_fault", {31'b0, rsp_fault}, {31'b0, e.fault});
      end
    end
  end

  // Called just after a posedge; returns just after the accepting posedge.
  task automatic issue(input logic [31:0] pc, input logic [31:0] ei, input logic ef);
    int unsigned n;
    n = 0;
    req_valid = 1'b1;
    req_pc    = pc;
    forever begin
      @(negedge clk);
      if (req_ready) break;
      n++;
      if (n > 50) break;
    end
    if (req_ready) exp_q.push_back('{instr: ei, pc: pc, fault: ef});
    else chk("accept_timeout", 32'(n), 32'd0);
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic load(input logic [31:0] a, input logic [31:0] d);
    load_en = 1'b1; load_addr = a; load_data = d;
    @(posedge clk); #1;
    load_en = 1'b0;
  endtask

  task automatic drain();
    int unsigned n;
    n = 0;
    while (exp_q.size() != 0 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain_left", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    @(posedge clk); #1;
    @(negedge clk);
    chk("ready_in_reset", {31'b0, req_ready}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("reset_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("reset_rsp_instr", rsp_instr, 32'd0);
    chk("reset_req_ready", {31'b0, req_ready}, 32'd1);
    @(posedge clk); #1;

    load(32'h0, W0);
    load(32'h4, W1);
    load(32'h8, W2);
    load(32'h6, 32'h1111_1111);   // misaligned: dropped
    load(32'h404, 32'h2222_2222); // out of range: dropped

    // Basic fetch with 1-cycle latency
    rsp_ready = 1'b1;
    issue(32'h0, W0, 1'b0);
    @(negedge clk);
    chk("latency_valid", {31'b0, rsp_valid}, 32'd1);
    @(posedge clk); #1;
    issue(32'h4, W1, 1'b0);
    drain();

    // Backpressure: third request stalls until the head is popped
    rsp_ready = 1'b0;
    issue(32'h0, W0, 1'b0);
    issue(32'h4, W1, 1'b0);
    fork
      issue(32'h8, W2, 1'b0);
      begin
        @(negedge clk);
        chk("full_ready", {31'b0, req_ready}, 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("full_ready2", {31'b0, req_ready}, 32'd0);
        @(posedge clk); #1;
        rsp_ready = 1'b1;
      end
    join
    drain();

    // Faulting addresses
    issue(32'h2, NOP, 1'b1);
    issue(32'h400, NOP, 1'b1);
    issue(32'h4, W1, 1'b0);
    drain();

    // Flush with a concurrent pop and request
    rsp_ready = 1'b0;
    issue(32'h0, W0, 1'b0);
    issue(32'h4, W1, 1'b0);
    flush = 1'b1; rsp_ready = 1'b1; req_valid = 1'b1; req_pc = 32'h8;
    exp_q.delete();
    @(negedge clk);
    chk("flush_req_ready", {31'b0, req_ready}, 32'd0);
    @(posedge clk); #1;
    flush = 1'b0; req_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("post_flush_valid", {31'b0, rsp_valid}, 32'd0);
      @(posedge clk); #1;
    end

    // Same-edge load/read collision returns the old word
    load_en = 1'b1; load_addr = 32'h8; load_data = WD;
    issue(32'h8, W2, 1'b0);
    load_en = 1'b0;
    issue(32'h8, WD, 1'b0);
    drain();

    // Reset while full; a load during reset is ignored
    rsp_ready = 1'b0;
    issue(32'h0, W0, 1'b0);
    issue(32'h4, W1, 1'b0);
    reset = 1'b1; load_en = 1'b1; load_addr = 32'h0; load_data = 32'h0BAD_BAD0;
    exp_q.delete();
    @(negedge clk);
    chk("reset_mid_ready", {31'b0, req_ready}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0; load_en = 1'b0;
    @(negedge clk);
    chk("rst2_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("rst2_rsp_instr", rsp_instr, 32'd0);
    chk("rst2_rsp_pc", rsp_pc, 32'd0);
    chk("rst2_rsp_fault", {31'b0, rsp_fault}, 32'd0);
    chk("rst2_req_ready", {31'b0, req_ready}, 32'd1);
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    issue(32'h0, W0, 1'b0);
    issue(32'h4, W1, 1'b0);
    issue(32'h8, WD, 1'b0);
    drain();

    repeat (3) @(posedge clk);
    chk("leftover", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
